// File: rtl/lfsr_prbs_gen_check.sv
// lfsr_prbs_gen_check: Galois LFSR pattern generator plus a self-synchronising checker.
//
// The generator steps a WIDTH-bit Galois LFSR (tap mask POLY, feedback into bit 0).
// The checker hunts for the same sequence in i_chk_data, locks after LOCK_CNT consecutive
// correct predictions, then free-runs its prediction and counts word errors until
// LOSS_CNT consecutive mismatches drop lock.
//
// Build option: define LFSR_ZERO_ESCAPE_EN to fold the all-zero state into the sequence
// (period 2^WIDTH for a primitive POLY, zero seed legal). Undefined: period 2^WIDTH-1 and
// the all-zero state locks up.
//
// Ports:
//   clk           system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_soft_reset  synchronous generator load from i_seed (beats i_valid)
//   i_seed        runtime generator seed
//   i_valid       advance generator one step
//   o_lfsr        generator state register
//   i_chk_valid   qualifier for i_chk_data
//   i_chk_data    received word to check
//   i_clr_err     synchronous clear of o_err_cnt (beats a same-cycle increment)
//   o_lock        checker locked
//   o_err         one-cycle pulse per mismatch while locked
//   o_err_cnt     saturating mismatch count
module lfsr_prbs_gen_check #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'('h1D),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'('h01),
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      LOSS_CNT = 4,
    parameter int unsigned      ERR_W    = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_soft_reset,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_lfsr,
    input  logic             i_chk_valid,
    input  logic [WIDTH-1:0] i_chk_data,
    input  logic             i_clr_err,
    output logic             o_lock,
    output logic             o_err,
    output logic [ERR_W-1:0] o_err_cnt
);

    localparam int unsigned MW = $clog2(LOCK_CNT + 1);
    localparam int unsigned LW = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {StHunt, StSync, StLock} chk_state_e;

    // Shared next-state function for generator and checker prediction.
    function automatic logic [WIDTH-1:0] lfsr_nxt(input logic [WIDTH-1:0] s);
        logic             fb;
        logic [WIDTH-1:0] n;
`ifdef LFSR_ZERO_ESCAPE_EN
        fb = s[WIDTH-1] ^ (s[WIDTH-2:0] == '0);
`else
        fb = s[WIDTH-1];
`endif
        n = {s[WIDTH-2:0], fb};
        n[WIDTH-1:1] = n[WIDTH-1:1] ^ (POLY[WIDTH-1:1] & {(WIDTH-1){fb}});
        return n;
    endfunction

    // ---------------- Generator ----------------
    logic [WIDTH-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (i_soft_reset) begin
            lfsr_d = i_seed;
        end else if (i_valid) begin
            lfsr_d = lfsr_nxt(lfsr_q);
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_lfsr = lfsr_q;

    // ---------------- Checker ----------------
    chk_state_e       state_q, state_d;
    logic [WIDTH-1:0] pred_q, pred_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [LW-1:0]    miss_cnt_q, miss_cnt_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    logic [MW-1:0] match_inc;
    logic [LW-1:0] miss_inc;
    logic          hit;
    logic          count_err;

    assign match_inc = match_cnt_q + MW'(1);
    assign miss_inc  = miss_cnt_q + LW'(1);
    assign hit       = (i_chk_data == pred_q);

    always_comb begin
        state_d     = state_q;
        pred_d      = pred_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        count_err   = 1'b0;
        if (i_chk_valid) begin
            unique case (state_q)
                StHunt: begin
                    pred_d      = lfsr_nxt(i_chk_data);
                    match_cnt_d = '0;
                    state_d     = StSync;
                end
                StSync: begin
                    // Reseeding from data on mismatch too, so the checker re-aligns.
                    pred_d = lfsr_nxt(i_chk_data);
                    if (hit) begin
                        if (match_inc == MW'(LOCK_CNT)) begin
                            state_d     = StLock;
                            match_cnt_d = '0;
                            miss_cnt_d  = '0;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                StLock: begin
                    // Free-running so corrupted words cannot pull the prediction off.
                    pred_d = lfsr_nxt(pred_q);
                    if (hit) begin
                        miss_cnt_d = '0;
                    end else begin
                        count_err = 1'b1;
                        if (miss_inc == LW'(LOSS_CNT)) begin
                            state_d    = StHunt;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_inc;
                        end
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_comb begin
        err_d     = count_err;
        err_cnt_d = err_cnt_q;
        if (i_clr_err) begin
            err_cnt_d = '0;
        end else if (count_err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StHunt;
            pred_q      <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            pred_q      <= pred_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_lock    = (state_q == StLock);
    assign o_err     = err_q;
    assign o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_lfsr_prbs_gen_check.sv
// Bench for lfsr_prbs_gen_check: default instance (u_dut) plus a small-counter instance
// (u_dut_sat, ERR_W = 2, LOSS_CNT = 8) whose checker listens to u_dut's generator.
module tb_lfsr_prbs_gen_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        soft_reset = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic        valid = 1'b0;
    logic [7:0]  lfsr;
    logic [7:0]  chk_data;
    logic        clr_err = 1'b0;
    logic        lock;
    logic        err;
    logic [15:0] err_cnt;
    logic [7:0]  corrupt = 8'h00;

    logic [7:0]  lfsr_s;
    logic [7:0]  chk_data_s;
    logic        clr_err_s = 1'b0;
    logic        lock_s;
    logic        err_s;
    logic [1:0]  err_cnt_s;
    logic [7:0]  corrupt_s = 8'h00;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [7:0]  exp_q[$];

`ifdef LFSR_ZERO_ESCAPE_EN
    localparam bit Esc = 1'b1;
    localparam int NT = 10;
    logic [7:0] tbl[NT] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h1D, 8'h3A};
`else
    localparam bit Esc = 1'b0;
    localparam int NT = 9;
    logic [7:0] tbl[NT] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
`endif

    always #5 clk = ~clk;

    assign chk_data   = lfsr ^ corrupt;
    assign chk_data_s = lfsr ^ corrupt_s;

    lfsr_prbs_gen_check u_dut (
        .clk          (clk),
        .i_rst        (rst),
        .i_soft_reset (soft_reset),
        .i_seed       (seed),
        .i_valid      (valid),
        .o_lfsr       (lfsr),
        .i_chk_valid  (valid),
        .i_chk_data   (chk_data),
        .i_clr_err    (clr_err),
        .o_lock       (lock),
        .o_err        (err),
        .o_err_cnt    (err_cnt)
    );

    lfsr_prbs_gen_check #(
        .ERR_W    (2),
        .LOSS_CNT (8)
    ) u_dut_sat (
        .clk          (clk),
        .i_rst        (rst),
        .i_soft_reset (1'b0),
        .i_seed       (8'h00),
        .i_valid      (1'b0),
        .o_lfsr       (lfsr_s),
        .i_chk_valid  (valid),
        .i_chk_data   (chk_data_s),
        .i_clr_err    (clr_err_s),
        .o_lock       (lock_s),
        .o_err        (err_s),
        .o_err_cnt    (err_cnt_s)
    );

    // Reference step: shift left, and on feedback XOR the full tap mask (bit 0 carries fb).
    function automatic logic [7:0] model_nxt(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ (Esc && (s[6:0] == 7'd0));
        return fb ? ((s << 1) ^ 8'h1D) : (s << 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One generator step: expected value queued at drive time, popped once o_lfsr updates.
    task automatic gen_step(input string tag, input logic [7:0] exp);
        logic [7:0] e;
        exp_q.push_back(exp);
        valid = 1'b1;
        step();
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(tag, 32'(lfsr), 32'(e));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;
        bit         seen[256];
        int         period;
        int         repeats;
        int         pulses;

        // Reset values
        #12;
        check_eq("rst_lfsr", 32'(lfsr), 32'h01);
        check_eq("rst_lock", 32'(lock), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Known opening sequence from SEED
        for (int i = 0; i < NT; i++) begin
            gen_step("seq", tbl[i]);
        end
        valid = 1'b0;

        // Full period from 01
        soft_reset = 1'b1;
        seed = 8'h01;
        step();
        soft_reset = 1'b0;
        check_eq("soft_seed01", 32'(lfsr), 32'h01);
        foreach (seen[i]) seen[i] = 1'b0;
        seen[1] = 1'b1;
        st = 8'h01;
        period = -1;
        repeats = 0;
        for (int i = 0; i < 300; i++) begin
            st = model_nxt(st);
            gen_step("period_seq", st);
            if (lfsr == 8'h01) begin
                period = i + 1;
                break;
            end
            if (seen[lfsr]) repeats++;
            seen[lfsr] = 1'b1;
        end
        valid = 1'b0;
        check_eq("period_len", 32'(period), Esc ? 32'd256 : 32'd255);
        check_eq("period_repeats", 32'(repeats), 32'd0);

        // Zero seed
        soft_reset = 1'b1;
        seed = 8'h00;
        step();
        soft_reset = 1'b0;
        check_eq("soft_seed00", 32'(lfsr), 32'h00);
        gen_step("zero_step1", Esc ? 8'h1D : 8'h00);
        if (!Esc) begin
            for (int i = 0; i < 4; i++) gen_step("zero_lockup", 8'h00);
        end

        // Soft reset wins over simultaneous valid
        soft_reset = 1'b1;
        seed = 8'hA5;
        valid = 1'b1;
        step();
        soft_reset = 1'b0;
        check_eq("soft_a5", 32'(lfsr), 32'hA5);
        gen_step("after_a5", model_nxt(8'hA5));

        // Asynchronous reset mid-stream, away from any edge
        #3;
        valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("async_rst_lfsr", 32'(lfsr), 32'h01);
        rst = 1'b0;
        gen_step("post_rst", 8'h02);
        valid = 1'b0;

        // Lock on looped-back sequence from HUNT
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step();
        valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_eq("lock_after4", 32'(lock), 32'd0);
        step();
        check_eq("lock_after5", 32'(lock), 32'd1);
        pulses = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (err) pulses++;
        end
        check_eq("clean_err_cnt", 32'(err_cnt), 32'd0);
        check_eq("clean_err_pulses", 32'(pulses), 32'd0);
        check_eq("clean_lock", 32'(lock), 32'd1);

        // Single corrupted word
        corrupt = 8'h08;
        step();
        corrupt = 8'h00;
        check_eq("flip_err", 32'(err), 32'd1);
        check_eq("flip_err_cnt", 32'(err_cnt), 32'd1);
        check_eq("flip_lock", 32'(lock), 32'd1);
        step();
        check_eq("flip_err_drop", 32'(err), 32'd0);
        check_eq("flip_lock_hold", 32'(lock), 32'd1);

        // Four consecutive corrupted words drop lock
        corrupt = 8'h08;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("burst_err", 32'(err), 32'd1);
        end
        corrupt = 8'h00;
        check_eq("burst_err_cnt", 32'(err_cnt), 32'd5);
        check_eq("burst_lock", 32'(lock), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check_eq("relock_after4", 32'(lock), 32'd0);
        check_eq("relock_err_pulse", 32'(err), 32'd0);
        step();
        check_eq("relock_after5", 32'(lock), 32'd1);
        check_eq("relock_err_cnt", 32'(err_cnt), 32'd5);

        // Saturating 2-bit counter, LOSS_CNT = 8
        check_eq("sat_locked", 32'(lock_s), 32'd1);
        corrupt_s = 8'hFF;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_eq("sat_cnt", 32'(err_cnt_s), (i < 3) ? 32'(i) : 32'd3);
        end
        check_eq("sat_lock_hold", 32'(lock_s), 32'd1);
        clr_err_s = 1'b1;
        step();
        clr_err_s = 1'b0;
        corrupt_s = 8'h00;
        check_eq("clr_wins_cnt", 32'(err_cnt_s), 32'd0);
        check_eq("clr_err_pulse", 32'(err_s), 32'd1);
        valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
